// File: rtl/drp_reg_bank.sv
// DRP register bank for the PLL/MMCM simulation models.
// Each DEN completes with a single DRDY pulse; protocol errors are flagged sticky in ERR.
module drp_reg_bank #(
    parameter int unsigned NUM_CLKOUT   = 7,
    parameter int unsigned DRDY_LATENCY = 3
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        PWRDWN,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [6:0]  DADDR,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DRDY,
    output logic        BUSY,
    output logic        WR_STB,
    output logic [6:0]  WR_ADDR,
    output logic [1:0]  ERR
);

    localparam int unsigned NumSlots = 23;
    localparam logic [3:0]  CntLoad  = 4'(DRDY_LATENCY - 1);

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    // Returns {hit, slot}; slot is 0 whenever hit is 0.
    function automatic logic [5:0] decode(input logic [6:0] addr);
        logic       hit;
        logic [4:0] idx;
        hit = 1'b0;
        idx = 5'd0;
        if (addr >= 7'h08 && addr <= 7'h11) begin
            idx = 5'(addr - 7'h08);
            hit = 32'(idx[4:1]) < NUM_CLKOUT;
        end else begin
            case (addr)
                7'h06, 7'h07: begin idx = {4'd5, addr[0]}; hit = NUM_CLKOUT > 5; end
                7'h12, 7'h13: begin idx = {4'd6, addr[0]}; hit = NUM_CLKOUT > 6; end
                7'h14, 7'h15: begin idx = {4'd7, addr[0]}; hit = 1'b1; end
                7'h16:        begin idx = 5'd16; hit = 1'b1; end
                7'h18:        begin idx = 5'd17; hit = 1'b1; end
                7'h19:        begin idx = 5'd18; hit = 1'b1; end
                7'h1A:        begin idx = 5'd19; hit = 1'b1; end
                7'h28:        begin idx = 5'd20; hit = 1'b1; end
                7'h4E:        begin idx = 5'd21; hit = 1'b1; end
                7'h4F:        begin idx = 5'd22; hit = 1'b1; end
                default:      begin idx = 5'd0; hit = 1'b0; end
            endcase
        end
        if (!hit) idx = 5'd0;
        return {hit, idx};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] do_q, do_d;
    logic        drdy_q, drdy_d;
    logic        stb_q, stb_d;
    logic [6:0]  wa_q, wa_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] regs_q [NumSlots];

    logic        reg_we;
    logic [4:0]  reg_idx;
    logic [5:0]  dec_in, dec_q;
    logic [15:0] rdata_in, rdata_q;

    assign dec_in   = decode(DADDR);
    assign dec_q    = decode(addr_q);
    assign rdata_in = dec_in[5] ? regs_q[dec_in[4:0]] : 16'h0000;
    assign rdata_q  = dec_q[5] ? regs_q[dec_q[4:0]] : 16'h0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        do_d    = do_q;
        drdy_d  = 1'b0;
        stb_d   = 1'b0;
        wa_d    = wa_q;
        err_d   = err_q;
        reg_we  = 1'b0;
        reg_idx = dec_in[4:0];
        if (PWRDWN) begin
            state_d = StIdle;
            do_d    = 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (DEN && drdy_q) begin
                        err_d[0] = 1'b1;
                    end else if (DEN) begin
                        we_d   = DWE;
                        addr_d = DADDR;
                        if (!dec_in[5]) err_d[1] = 1'b1;
                        if (DWE && dec_in[5]) begin
                            reg_we = 1'b1;
                            stb_d  = 1'b1;
                            wa_d   = DADDR;
                        end
                        // Single-cycle latency completes on the accept edge itself so
                        // back-to-back transactions every second cycle are legal.
                        if (DRDY_LATENCY == 1) begin
                            drdy_d = 1'b1;
                            if (!DWE) do_d = rdata_in;
                        end else begin
                            state_d = StWait;
                            cnt_d   = CntLoad;
                        end
                    end
                end
                StWait: begin
                    if (DEN) err_d[0] = 1'b1;
                    if (cnt_q == 4'd0) begin
                        drdy_d  = 1'b1;
                        state_d = StIdle;
                        if (!we_q) do_d = rdata_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 7'd0;
            do_q    <= 16'h0000;
            drdy_q  <= 1'b0;
            stb_q   <= 1'b0;
            wa_q    <= 7'd0;
            err_q   <= 2'b00;
            for (int i = 0; i < NumSlots; i++) regs_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            do_q    <= do_d;
            drdy_q  <= drdy_d;
            stb_q   <= stb_d;
            wa_q    <= wa_d;
            err_q   <= err_d;
            if (reg_we) regs_q[reg_idx] <= DI;
        end
    end

    assign DO      = do_q;
    assign DRDY    = drdy_q;
    assign BUSY    = (state_q == StWait);
    assign WR_STB  = stb_q;
    assign WR_ADDR = wa_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_drp_reg_bank.sv
// Bench for drp_reg_bank: two configurations driven in lockstep and compared every cycle
// against a transaction-level model keyed by address.
module tb_drp_reg_bank;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1, PWRDWN = 1'b0, DEN = 1'b0, DWE = 1'b0;
    logic [6:0]  DADDR = '0;
    logic [15:0] DI = '0;

    logic [15:0] d_do   [2];
    logic        d_drdy [2];
    logic        d_busy [2];
    logic        d_stb  [2];
    logic [6:0]  d_wa   [2];
    logic [1:0]  d_err  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 DCLK = ~DCLK;

    drp_reg_bank #(.NUM_CLKOUT(5), .DRDY_LATENCY(3)) u_dut_a (
        .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI),
        .DO(d_do[0]), .DRDY(d_drdy[0]), .BUSY(d_busy[0]), .WR_STB(d_stb[0]),
        .WR_ADDR(d_wa[0]), .ERR(d_err[0])
    );

    drp_reg_bank #(.NUM_CLKOUT(7), .DRDY_LATENCY(1)) u_dut_b (
        .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI),
        .DO(d_do[1]), .DRDY(d_drdy[1]), .BUSY(d_busy[1]), .WR_STB(d_stb[1]),
        .WR_ADDR(d_wa[1]), .ERR(d_err[1])
    );

    // Reference model state per instance
    int          lat [2] = '{3, 1};
    int          ncl [2] = '{5, 7};
    logic [15:0] m_mem  [2][128];
    bit          m_pend [2];
    int          m_due  [2];
    bit          m_rd   [2];
    logic [6:0]  m_addr [2];
    logic [15:0] m_do   [2];
    bit          m_drdy [2];
    bit          m_stb  [2];
    logic [6:0]  m_wa   [2];
    logic [1:0]  m_err  [2];
    int          t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    endtask

    function automatic bit mapped(input int n, input logic [6:0] a);
        int v;
        int pairs;
        v = int'(a);
        pairs = (n < 5) ? n : 5;
        if (v >= 8 && v < 8 + 2 * pairs) return 1'b1;
        if (n > 5 && (v == 6 || v == 7)) return 1'b1;
        if (n > 6 && (v == 'h12 || v == 'h13)) return 1'b1;
        return (v == 'h14 || v == 'h15 || v == 'h16 || v == 'h18 || v == 'h19 || v == 'h1A ||
                v == 'h28 || v == 'h4E || v == 'h4F);
    endfunction

    task automatic model_step(input int i);
        bit was_pend;
        bit prev_drdy;
        bit hit;
        if (RST) begin
            for (int a = 0; a < 128; a++) m_mem[i][a] = 16'h0000;
            m_pend[i] = 0; m_do[i] = 0; m_drdy[i] = 0; m_stb[i] = 0; m_wa[i] = 0; m_err[i] = 0;
            return;
        end
        was_pend  = m_pend[i];
        prev_drdy = m_drdy[i];
        m_drdy[i] = 0;
        m_stb[i]  = 0;
        if (PWRDWN) begin
            m_pend[i] = 0;
            m_do[i]   = 16'h0000;
            return;
        end
        if (was_pend && t == m_due[i]) begin
            m_drdy[i] = 1;
            m_pend[i] = 0;
            if (m_rd[i]) m_do[i] = mapped(ncl[i], m_addr[i]) ? m_mem[i][m_addr[i]] : 16'h0000;
        end
        if (DEN) begin
            if (was_pend || prev_drdy) begin
                m_err[i][0] = 1'b1;
            end else begin
                hit = mapped(ncl[i], DADDR);
                if (!hit) m_err[i][1] = 1'b1;
                if (!DWE) begin
                    if (lat[i] == 1) m_do[i] = hit ? m_mem[i][DADDR] : 16'h0000;
                end else if (hit) begin
                    m_mem[i][DADDR] = DI;
                    m_stb[i] = 1;
                    m_wa[i]  = DADDR;
                end
                if (lat[i] == 1) begin
                    m_drdy[i] = 1;
                end else begin
                    m_pend[i] = 1;
                    m_due[i]  = t + lat[i];
                    m_rd[i]   = !DWE;
                    m_addr[i] = DADDR;
                end
            end
        end
    endtask

    task automatic check_all(input int i);
        string p;
        p = (i == 0) ? "a" : "b";
        check({p, ".DO"},      32'(d_do[i]),   32'(m_do[i]));
        check({p, ".DRDY"},    32'(d_drdy[i]), 32'(m_drdy[i]));
        check({p, ".BUSY"},    32'(d_busy[i]), 32'(m_pend[i]));
        check({p, ".WR_STB"},  32'(d_stb[i]),  32'(m_stb[i]));
        check({p, ".WR_ADDR"}, 32'(d_wa[i]),   32'(m_wa[i]));
        check({p, ".ERR"},     32'(d_err[i]),  32'(m_err[i]));
    endtask

    task automatic cycle(input bit rst, input bit pd, input bit den, input bit dwe,
                         input logic [6:0] a, input logic [15:0] d);
        RST = rst; PWRDWN = pd; DEN = den; DWE = dwe; DADDR = a; DI = d;
        @(posedge DCLK);
        t++;
        model_step(0);
        model_step(1);
        @(negedge DCLK);
        check_all(0);
        check_all(1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 7'h00, 16'h0000);
    endtask

    logic [6:0] pick [19] = '{7'h08, 7'h09, 7'h10, 7'h11, 7'h06, 7'h07, 7'h12, 7'h13, 7'h14,
                              7'h16, 7'h18, 7'h1A, 7'h28, 7'h4E, 7'h4F, 7'h00, 7'h17, 7'h7F,
                              7'h0C};

    initial begin
        cycle(1, 0, 0, 0, 7'h00, 16'h0000);
        cycle(1, 0, 0, 0, 7'h00, 16'h0000);
        idle(1);
        // Write then read back a CLKOUT0 register
        cycle(0, 0, 1, 1, 7'h08, 16'hA5A5); idle(4);
        cycle(0, 0, 1, 0, 7'h08, 16'h0000); idle(4);
        // CLKOUT6 pair: unmapped for the 5-output instance
        cycle(0, 0, 1, 1, 7'h12, 16'h1234); idle(4);
        cycle(0, 0, 1, 0, 7'h12, 16'h0000); idle(4);
        // Second DEN one cycle after the first
        cycle(0, 0, 1, 0, 7'h16, 16'h0000);
        cycle(0, 0, 1, 0, 7'h16, 16'h0000); idle(4);
        // Power-down aborts an in-flight read
        cycle(0, 0, 1, 0, 7'h28, 16'h0000);
        cycle(0, 1, 0, 0, 7'h00, 16'h0000);
        cycle(0, 1, 1, 0, 7'h28, 16'h0000);
        idle(1);
        cycle(0, 0, 1, 0, 7'h28, 16'h0000); idle(4);
        // Reset clears registers and sticky errors
        cycle(0, 0, 1, 1, 7'h4E, 16'hFFFF); idle(4);
        cycle(1, 0, 0, 0, 7'h00, 16'h0000);
        idle(1);
        cycle(0, 0, 1, 0, 7'h4E, 16'h0000); idle(4);
        // Reads every second cycle
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 1, 0, 7'h18, 16'h0000);
            idle(1);
        end
        idle(4);
        for (int k = 0; k < 4000; k++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pick[$urandom_range(0, 18)];
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 4), 1'($urandom), a, 16'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
